// File: rtl/imem_arb_pkg.sv
// ----------------------------------------------------------------------------
// imem_arb_pkg
//   Shared definitions for the instruction-memory arbiter:
//     - state_t : arbiter FSM encoding (IDLE / ISSUE / WAIT)
//     - rr_next : round-robin pointer advance with explicit wrap, so that
//                 non-power-of-2 core counts work without relying on overflow.
// ----------------------------------------------------------------------------
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Returns (ptr + 1) mod n by compare rather than by overflow.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational rotating-priority picker. Selects the first asserted
//   request at or after ptr, wrapping to index 0. The pointer itself is owned
//   by the caller.
// Ports
//   req  in  N         request vector
//   ptr  in  log2(N)   highest-priority index this cycle
//   gnt  out N         one-hot selection (all zero when no request)
//   idx  out log2(N)   binary index of the selection
//   any  out 1         at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // NOTE: every output of a combinational block gets a default assignment
  // first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    any = 1'b0;
    idx = '0;
    gnt = '0;
    // Pass 1: lowest requester overall -- the wrapped-around fallback.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
    // Pass 2: lowest requester at or after ptr overrides the fallback.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) >= ptr)) begin
        idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = any && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_arbiter
//   Shares one single-ported instruction memory among NUM_CORES fetch stages.
//   A requester is chosen round-robin in IDLE, its PC is captured, the read is
//   issued (held until mem_ready), and the returned instruction is flagged to
//   the owning core. Only one memory read is ever outstanding.
// Ports
//   clk, rst      clock / synchronous active-high reset
//   core_req      per-core fetch request, held until granted
//   core_addr     per-core PC, core i at [i*ADDR_W +: ADDR_W]
//   core_gnt      one-hot pulse: request accepted, address captured
//   core_rvalid   one-hot pulse: core_rdata valid for that core
//   core_rdata    instruction, shared by all cores (straight from mem_rdata)
//   mem_req       read request to IMEM
//   mem_addr      read address to IMEM
//   mem_ready     IMEM accepts mem_req this cycle
//   mem_rvalid    IMEM read data valid
//   mem_rdata     IMEM read data
//   busy          FSM not in IDLE
// ----------------------------------------------------------------------------
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int PTR_W = $clog2(NUM_CORES);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   rr_ptr;

  logic [NUM_CORES-1:0] arb_gnt;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 take;

  rr_arbiter #(
    .N     (NUM_CORES),
    .IDX_W (PTR_W)
  ) u_rr (
    .req (core_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // A grant happens only from IDLE; requests during ISSUE/WAIT wait their turn.
  assign take = (state_q == IDLE) && arb_any;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (arb_idx == PTR_W'(i)) sel_addr = core_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. mem_rvalid outside WAIT has no effect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_any)    state_d = ISSUE;
      ISSUE:   if (mem_ready)  state_d = WAIT;
      WAIT:    if (mem_rvalid) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Captured transaction context and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (take) begin
      addr_q <= sel_addr;
      owner  <= arb_idx;
      rr_ptr <= PTR_W'(rr_next(32'(arb_idx), NUM_CORES));
    end
  end

  // Output decode.
  always_comb begin
    core_gnt    = '0;
    core_rvalid = '0;
    mem_req     = 1'b0;
    busy        = (state_q != IDLE);
    if (take) core_gnt = arb_gnt;
    if (state_q == ISSUE) mem_req = 1'b1;
    if ((state_q == WAIT) && mem_rvalid) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        core_rvalid[i] = (owner == PTR_W'(i));
      end
    end
  end

  // addr_q only changes on a grant, so mem_addr is stable while ISSUE waits.
  assign mem_addr   = addr_q;
  assign core_rdata = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_imem_arbiter
//   Directed scenarios for imem_arbiter (NUM_CORES=4). Inputs change 1ns after
//   a rising edge and outputs are observed 1ns later, well away from the edge.
// ----------------------------------------------------------------------------
module tb_imem_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   core_req;
  logic [NC*AW-1:0] core_addr;
  logic [NC-1:0]   core_gnt;
  logic [NC-1:0]   core_rvalid;
  logic [DW-1:0]   core_rdata;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_addr   (core_addr),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one best-case transaction (ready in ISSUE, rvalid next).
  task automatic run_txn(input logic [NC-1:0] req, input logic hold, input logic [DW-1:0] rdata,
                         output logic [NC-1:0] gnt_o, output logic [AW-1:0] addr_o,
                         output logic [NC-1:0] rv_o);
    core_req = req;
    #1 gnt_o = core_gnt;
    cycle();
    if (!hold) core_req = '0;
    mem_ready = 1'b1;
    #1 addr_o = mem_req ? mem_addr : 'x;
    cycle();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    #1 rv_o = core_rvalid;
    cycle();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; core_req = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    cycle(); cycle();
    rst = 1'b0;
    #1;
    n_cmp++; if (core_gnt !== '0) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", core_gnt); end
    n_cmp++; if (core_rvalid !== '0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0000", core_rvalid); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    cycle();
  endtask

  task automatic test_single();
    core_req = 4'b0100;
    #1;
    n_cmp++; if (core_gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b want 0100", core_gnt); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL single_req_T: got %b want 0", mem_req); end
    cycle();
    core_req = '0; mem_ready = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL single_mem_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL single_mem_addr: got %h want 00000100", mem_addr); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    cycle();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (core_rvalid !== 4'b0100) begin n_err++; $display("FAIL single_rvalid: got %b want 0100", core_rvalid); end
    n_cmp++; if (core_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rdata: got %h want deadbeef", core_rdata); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL single_req_wait: got %b want 0", mem_req); end
    cycle();
    mem_rvalid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", busy); end
    n_cmp++; if (core_rvalid !== '0) begin n_err++; $display("FAIL single_rvalid_off: got %b want 0000", core_rvalid); end
  endtask

  task automatic test_rotation();
    logic [NC-1:0] exp_gnt [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [AW-1:0] exp_addr [6] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1000, 32'h1004};
    logic [NC-1:0] g, rv;
    logic [AW-1:0] a;
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_txn(4'b1111, 1'b1, 32'hA000_0000 + i, g, a, rv);
      n_cmp++; if (g !== exp_gnt[i]) begin n_err++; $display("FAIL rot_gnt[%0d]: got %b want %b", i, g, exp_gnt[i]); end
      n_cmp++; if (a !== exp_addr[i]) begin n_err++; $display("FAIL rot_addr[%0d]: got %h want %h", i, a, exp_addr[i]); end
      n_cmp++; if (rv !== exp_gnt[i]) begin n_err++; $display("FAIL rot_rvalid[%0d]: got %b want %b", i, rv, exp_gnt[i]); end
    end
    core_req = '0;
  endtask

  // rr_ptr is 2 here (last grant was core 1).
  task automatic test_backpressure();
    core_req = 4'b1111;
    #1;
    n_cmp++; if (core_gnt !== 4'b0100) begin n_err++; $display("FAIL bp_gnt: got %b want 0100", core_gnt); end
    cycle();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = (i == 2);  // stray data while ISSUE must be ignored
      #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL bp_mem_req[%0d]: got %b want 1", i, mem_req); end
      n_cmp++; if (mem_addr !== 32'h1008) begin n_err++; $display("FAIL bp_mem_addr[%0d]: got %h want 00001008", i, mem_addr); end
      n_cmp++; if (core_gnt !== '0) begin n_err++; $display("FAIL bp_no_gnt[%0d]: got %b want 0000", i, core_gnt); end
      n_cmp++; if (core_rvalid !== '0) begin n_err++; $display("FAIL bp_rvalid[%0d]: got %b want 0000", i, core_rvalid); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy[%0d]: got %b want 1", i, busy); end
      cycle();
    end
    mem_rvalid = 1'b0; mem_ready = 1'b1; core_req = '0;
    #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b want 1", mem_req); end
    cycle();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    #1;
    n_cmp++; if (core_rvalid !== 4'b0100) begin n_err++; $display("FAIL bp_rvalid_end: got %b want 0100", core_rvalid); end
    cycle();
    mem_rvalid = 1'b0;
  endtask

  // rr_ptr is 3 here (last grant was core 2).
  task automatic test_wrap();
    logic [NC-1:0] g, rv;
    logic [AW-1:0] a;
    run_txn(4'b0011, 1'b1, 32'h1111_1111, g, a, rv);
    n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL wrap_first: got %b want 0001", g); end
    run_txn(4'b0011, 1'b0, 32'h2222_2222, g, a, rv);
    n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL wrap_second: got %b want 0010", g); end
    n_cmp++; if (rv !== 4'b0010) begin n_err++; $display("FAIL wrap_rvalid: got %b want 0010", rv); end
  endtask

  // rr_ptr is 2 here; grant core 1 keeps it at 2 until reset clears it.
  task automatic test_reset_mid_wait();
    logic [NC-1:0] g, rv;
    logic [AW-1:0] a;
    core_req = 4'b0010;
    #1;
    n_cmp++; if (core_gnt !== 4'b0010) begin n_err++; $display("FAIL rmw_gnt: got %b want 0010", core_gnt); end
    cycle();
    core_req = '0; mem_ready = 1'b1;
    cycle();
    mem_ready = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    #1;
    n_cmp++; if (core_rvalid !== '0) begin n_err++; $display("FAIL rmw_rvalid: got %b want 0000", core_rvalid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmw_busy: got %b want 0", busy); end
    cycle();
    mem_rvalid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmw_busy_after: got %b want 0", busy); end
    // Pointer back at 0 picks core 1 out of {1,3}; a stale pointer of 2 would pick core 3.
    run_txn(4'b1010, 1'b0, 32'h3333_3333, g, a, rv);
    n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL rmw_ptr0: got %b want 0010", g); end
    run_txn(4'b1000, 1'b0, 32'h4444_4444, g, a, rv);
    n_cmp++; if (g !== 4'b1000) begin n_err++; $display("FAIL rmw_core3: got %b want 1000", g); end
    n_cmp++; if (a !== 32'h100C) begin n_err++; $display("FAIL rmw_addr: got %h want 0000100c", a); end
    n_cmp++; if (rv !== 4'b1000) begin n_err++; $display("FAIL rmw_rv3: got %b want 1000", rv); end
  endtask

  task automatic test_stray_rvalid();
    core_req = '0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (core_rvalid !== '0) begin n_err++; $display("FAIL stray_rvalid[%0d]: got %b want 0000", i, core_rvalid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stray_busy[%0d]: got %b want 0", i, busy); end
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL stray_mem_req[%0d]: got %b want 0", i, mem_req); end
      cycle();
    end
    mem_rvalid = 1'b0;
    // Still IDLE: an immediate request is granted in the same cycle (rr_ptr=0).
    core_req = 4'b0001;
    #1;
    n_cmp++; if (core_gnt !== 4'b0001) begin n_err++; $display("FAIL stray_then_gnt: got %b want 0001", core_gnt); end
    cycle();
    core_req = '0;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stray_then_busy: got %b want 1", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NC; i++) core_addr[i*AW +: AW] = 32'h1000 + 32'(i * 4);
    core_addr[2*AW +: AW] = 32'h100;
    rst = 1'b1; core_req = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    test_reset();
    test_single();
    core_addr[2*AW +: AW] = 32'h1008;
    test_rotation();
    test_backpressure();
    test_wrap();
    test_reset_mid_wait();
    test_stray_rvalid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
